// File: rtl/uart_pkg.sv
// Shared state encoding and parity constants for the parameterised UART transmitter.
package uart_pkg;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_CHECK  = 3'd5
    } tx_state_t;

    // Parity bit from the XOR-reduction of the word: as-is for even, inverted for odd.
    function automatic logic parity_bit(input int mode, input logic xor_red);
        return (mode == PARITY_ODD) ? ~xor_red : xor_red;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Input FIFO of the UART transmitter: power-of-two depth, wrapping pointers, occupancy counter.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_push,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_pop,
    output logic [DATA_W-1:0]             o_data,
    output logic                          o_full,
    output logic                          o_empty,
    output logic [$clog2(FIFO_DEPTH):0]   o_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr];

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with input FIFO, optional parity, 1/2 stop bits and
// NACK-driven retransmission. The serial line is registered, so it lags the state by one edge.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1,
    parameter int MAX_RETRY   = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                         CLK_Baudin,
    input  logic                         RstTx_n,
    input  logic [DATA_W-1:0]            DataIn,
    input  logic                         NewData,
    output logic                         Ready,
    input  logic                         Flag_in,
    output logic                         TransmittedSerialData,
    output logic                         DoneTx,
    output logic                         ErrTx,
    output logic                         Busy,
    output logic [2:0]                   o_dbg_state,
    output logic [$clog2(FIFO_DEPTH):0]  o_dbg_fifo_count
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam int RTY_W = $clog2(MAX_RETRY + 2);

    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [RTY_W-1:0]  r_retry;
    logic [RTY_W-1:0]  w_retry_nxt;
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] w_shift_nxt;
    logic [DATA_W-1:0] r_hold;
    logic [DATA_W-1:0] w_hold_nxt;
    logic              r_tx;
    logic              w_tx_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_err;
    logic              w_err_nxt;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [DATA_W-1:0] w_fifo_data;

    // Handshake: a word is taken on every rising edge where NewData and Ready are both high;
    // Ready is low only while the FIFO is full, and a push seen then is simply dropped.
    uart_tx_fifo #(
        .DATA_W     (DATA_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLK_Baudin),
        .rst_n   (RstTx_n),
        .i_push  (NewData),
        .i_data  (DataIn),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (o_dbg_fifo_count)
    );

    assign Ready                 = !w_full;
    assign TransmittedSerialData = r_tx;
    assign DoneTx                = r_done;
    assign ErrTx                 = r_err;
    assign Busy                  = (r_state != ST_IDLE);
    assign o_dbg_state           = r_state;

    always_ff @(posedge CLK_Baudin or negedge RstTx_n) begin
        if (!RstTx_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_bit_cnt;
        w_retry_nxt = r_retry;
        w_shift_nxt = r_shift;
        w_hold_nxt  = r_hold;
        w_pop       = 1'b0;
        w_tx_nxt    = 1'b1;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_data;
                    w_hold_nxt  = w_fifo_data;
                    w_retry_nxt = '0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                w_tx_nxt    = 1'b0;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_DATA;
            end
            ST_DATA: begin
                w_tx_nxt    = r_shift[0];
                w_shift_nxt = r_shift >> 1;
                if (r_bit_cnt == CNT_W'(DATA_W - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
                end else begin
                    w_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            ST_PARITY: begin
                w_tx_nxt    = parity_bit(PARITY_MODE, ^r_hold);
                w_cnt_nxt   = '0;
                w_state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (r_bit_cnt == CNT_W'(STOP_BITS - 1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_cnt_nxt = r_bit_cnt + 1'b1;
                end
            end
            ST_CHECK: begin
                // A retry replays the held word; the FIFO is untouched until the frame resolves.
                if (!Flag_in) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_retry < RTY_W'(MAX_RETRY)) begin
                    w_retry_nxt = r_retry + 1'b1;
                    w_shift_nxt = r_hold;
                    w_state_nxt = ST_START;
                end else begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK_Baudin or negedge RstTx_n) begin
        if (!RstTx_n) begin
            r_bit_cnt <= '0;
            r_retry   <= '0;
            r_shift   <= '0;
            r_hold    <= '0;
            r_tx      <= 1'b1;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_bit_cnt <= w_cnt_nxt;
            r_retry   <= w_retry_nxt;
            r_shift   <= w_shift_nxt;
            r_hold    <= w_hold_nxt;
            r_tx      <= w_tx_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: a default instance and an odd-parity / two-stop-bit instance.
module tb_uart_tx_param;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data_a, data_b;
    logic       nd_a, nd_b, flag_a, flag_b;
    logic       ready_a, ready_b, tx_a, tx_b;
    logic       done_a, done_b, err_a, err_b, busy_a, busy_b;
    logic [2:0] st_a, st_b;
    logic [2:0] cnt_a, cnt_b;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];

    logic       mon_sel = 1'b0;
    logic       mon_line, mon_done, mon_err, mon_busy;

    assign mon_line = mon_sel ? tx_b   : tx_a;
    assign mon_done = mon_sel ? done_b : done_a;
    assign mon_err  = mon_sel ? err_b  : err_a;
    assign mon_busy = mon_sel ? busy_b : busy_a;

    always #5 clk = ~clk;

    uart_tx_param dut_a (
        .CLK_Baudin            (clk),
        .RstTx_n               (rst_n),
        .DataIn                (data_a),
        .NewData               (nd_a),
        .Ready                 (ready_a),
        .Flag_in               (flag_a),
        .TransmittedSerialData (tx_a),
        .DoneTx                (done_a),
        .ErrTx                 (err_a),
        .Busy                  (busy_a),
        .o_dbg_state           (st_a),
        .o_dbg_fifo_count      (cnt_a)
    );

    uart_tx_param #(
        .DATA_W      (8),
        .PARITY_MODE (2),
        .STOP_BITS   (2),
        .MAX_RETRY   (3),
        .FIFO_DEPTH  (4)
    ) dut_b (
        .CLK_Baudin            (clk),
        .RstTx_n               (rst_n),
        .DataIn                (data_b),
        .NewData               (nd_b),
        .Ready                 (ready_b),
        .Flag_in               (flag_b),
        .TransmittedSerialData (tx_b),
        .DoneTx                (done_b),
        .ErrTx                 (err_b),
        .Busy                  (busy_b),
        .o_dbg_state           (st_b),
        .o_dbg_fifo_count      (cnt_b)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic sel, input logic [7:0] d);
        @(posedge clk);
        #1;
        if (sel) begin
            data_b = d;
            nd_b   = 1'b1;
        end else begin
            data_a = d;
            nd_a   = 1'b1;
        end
        exp_q.push_back(d);
        @(negedge clk);
        chk1("push_ready", sel ? ready_b : ready_a, 1'b1);
        @(posedge clk);
        #1;
        nd_a = 1'b0;
        nd_b = 1'b0;
    endtask

    task automatic wait_start(output logic ok);
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (mon_line === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic capture_frame(input logic sel, input logic flag, input logic exp_done,
                                 input logic exp_err, input string tag);
        logic       ok;
        logic [7:0] word;
        logic [7:0] exp_w;
        logic       exp_par;
        int         par_mode;
        int         n_stop;
        int         flen;
        int         pulse_idx;
        mon_sel  = sel;
        par_mode = sel ? 2 : 1;
        n_stop   = sel ? 2 : 1;
        flen     = 1 + 8 + ((par_mode != 0) ? 1 : 0) + n_stop + 1;
        if (sel) flag_b = flag;
        else     flag_a = flag;
        wait_start(ok);
        chk1({tag, "_start_seen"}, ok, 1'b1);
        if (!ok) return;
        chk1({tag, "_busy_at_start"}, mon_busy, 1'b1);
        chk1({tag, "_sb_nonempty"}, exp_q.size() > 0, 1'b1);
        exp_w     = (exp_q.size() > 0) ? exp_q[0] : 8'h00;
        exp_par   = (^exp_w) ^ (par_mode == 2);
        word      = '0;
        pulse_idx = (mon_done || mon_err) ? 0 : -1;
        for (int idx = 1; idx < flen; idx++) begin
            @(negedge clk);
            if ((mon_done || mon_err) && pulse_idx < 0) pulse_idx = idx;
            if (idx <= 8) begin
                word[idx-1] = mon_line;
            end else if (par_mode != 0 && idx == 9) begin
                chk1({tag, "_parity"}, mon_line, exp_par);
            end else begin
                chk1({tag, "_stop_check_high"}, mon_line, 1'b1);
            end
        end
        chk32({tag, "_data"}, 32'(word), 32'(exp_w));
        chk1({tag, "_done"}, mon_done, exp_done);
        chk1({tag, "_err"}, mon_err, exp_err);
        chk1({tag, "_busy_end"}, mon_busy, !(exp_done || exp_err));
        chk32({tag, "_pulse_pos"}, pulse_idx, (exp_done || exp_err) ? flen - 1 : -1);
        if (exp_done || exp_err) begin
            void'(exp_q.pop_front());
            @(negedge clk);
            chk1({tag, "_pulse_one_cycle"}, mon_done || mon_err, 1'b0);
        end
    endtask

    initial begin
        logic ok;
        int   n_low;
        int   n_done;
        rst_n  = 1'b0;
        nd_a   = 1'b0;
        nd_b   = 1'b0;
        data_a = '0;
        data_b = '0;
        flag_a = 1'b0;
        flag_b = 1'b0;
        repeat (3) @(negedge clk);
        chk1("rst_line_a", tx_a, 1'b1);
        chk1("rst_line_b", tx_b, 1'b1);
        chk1("rst_done", done_a, 1'b0);
        chk1("rst_err", err_a, 1'b0);
        chk1("rst_busy", busy_a, 1'b0);
        chk1("rst_ready", ready_a, 1'b1);
        chk32("rst_count", 32'(cnt_a), 32'd0);
        chk32("rst_state", 32'(st_a), 32'd0);

        // First frame after release: push lands on edge 1, pop on edge 2, start bit on edge 3.
        data_a = 8'hC3;
        nd_a   = 1'b1;
        exp_q.push_back(8'hC3);
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        nd_a = 1'b0;
        @(negedge clk);
        chk1("rel_edge1_line", tx_a, 1'b1);
        chk32("rel_edge1_count", 32'(cnt_a), 32'd1);
        @(negedge clk);
        chk1("rel_edge2_line", tx_a, 1'b1);
        chk1("rel_edge2_busy", busy_a, 1'b1);
        capture_frame(1'b0, 1'b0, 1'b1, 1'b0, "c3");

        push_word(1'b0, 8'hA5);
        capture_frame(1'b0, 1'b0, 1'b1, 1'b0, "even_a5");

        push_word(1'b1, 8'hA5);
        capture_frame(1'b1, 1'b0, 1'b1, 1'b0, "odd_a5");

        fork
            begin
                for (int i = 0; i < 3; i++) push_word(1'b0, 8'($urandom_range(0, 255)));
            end
            begin
                for (int i = 0; i < 3; i++) capture_frame(1'b0, 1'b0, 1'b1, 1'b0, "rand");
            end
        join

        push_word(1'b0, 8'h3C);
        capture_frame(1'b0, 1'b1, 1'b0, 1'b0, "nack1");
        capture_frame(1'b0, 1'b1, 1'b0, 1'b0, "nack2");
        capture_frame(1'b0, 1'b0, 1'b1, 1'b0, "ack3");

        fork
            begin
                push_word(1'b0, 8'h5A);
                push_word(1'b0, 8'h81);
            end
            begin
                for (int i = 0; i < 3; i++) capture_frame(1'b0, 1'b1, 1'b0, 1'b0, "retry");
                capture_frame(1'b0, 1'b1, 1'b0, 1'b1, "exhaust");
                capture_frame(1'b0, 1'b0, 1'b1, 1'b0, "after_err");
            end
        join

        fork
            begin
                for (int i = 1; i <= 6; i++) begin
                    @(posedge clk);
                    #1;
                    data_a = 8'(i);
                    nd_a   = 1'b1;
                    if (i <= 5) exp_q.push_back(8'(i));
                    @(negedge clk);
                    chk1("burst_ready", ready_a, i <= 5);
                end
                @(posedge clk);
                #1;
                nd_a = 1'b0;
            end
            begin
                for (int i = 0; i < 5; i++) capture_frame(1'b0, 1'b0, 1'b1, 1'b0, "burst");
            end
        join
        n_low = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_a !== 1'b1) n_low++;
        end
        chk32("burst_no_sixth", n_low, 0);
        chk32("burst_sb_drained", exp_q.size(), 0);

        fork
            begin
                push_word(1'b0, 8'h11);
                push_word(1'b0, 8'h22);
                push_word(1'b0, 8'h33);
            end
            begin
                capture_frame(1'b0, 1'b0, 1'b1, 1'b0, "pre_rst");
                wait_start(ok);
                chk1("mid_rst_start_seen", ok, 1'b1);
                repeat (3) @(negedge clk);
                #1;
                rst_n = 1'b0;
                #1;
                chk1("mid_rst_line", tx_a, 1'b1);
                chk1("mid_rst_busy", busy_a, 1'b0);
                chk1("mid_rst_done", done_a, 1'b0);
                chk1("mid_rst_ready", ready_a, 1'b1);
                chk32("mid_rst_count", 32'(cnt_a), 32'd0);
            end
        join
        exp_q.delete();
        @(negedge clk);
        rst_n  = 1'b1;
        n_low  = 0;
        n_done = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_a !== 1'b1) n_low++;
            if (done_a !== 1'b0) n_done++;
        end
        chk32("post_rst_idle_line", n_low, 0);
        chk32("post_rst_no_done", n_done, 0);
        push_word(1'b0, 8'h7E);
        capture_frame(1'b0, 1'b0, 1'b1, 1'b0, "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data bits per frame (legal range 5..32).
REQ-002 SHALL have parameter PARITY_MODE, default 1, parity mode: 0 none, 1 even, 2 odd.
REQ-003 SHALL have parameter STOP_BITS, default 1, stop bits per frame (1 or 2).
REQ-004 SHALL have parameter MAX_RETRY, default 3, maximum retransmissions after NACK.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, input FIFO entries (power of two, at least 2).
REQ-006 SHALL have port CLK_Baudin  in  1  single clock, one serial bit per cycle.
REQ-007 SHALL have port RstTx_n  in  1  reset, asynchronous, active-low.
REQ-008 SHALL have port DataIn  in  DATA_W  word to transmit.
REQ-009 SHALL have port NewData  in  1  push strobe; a word is accepted when NewData and Ready are both 1.
REQ-010 SHALL have port Ready  out  1  FIFO not full.
REQ-011 SHALL have port Flag_in  in  1  receiver NACK, sampled only in the CHECK state.
REQ-012 SHALL have port TransmittedSerialData  out  1  registered serial line, idle high.
REQ-013 SHALL have port DoneTx  out  1  one-cycle pulse when a frame is acknowledged.
REQ-014 SHALL have port ErrTx  out  1  one-cycle pulse when the retry budget is exhausted and the frame is dropped.
REQ-015 SHALL have port Busy  out  1  high whenever the state is not IDLE.

Function
REQ-016 SHALL implement a state machine with states IDLE, START, DATA, PARITY, STOP and CHECK.
REQ-017 In IDLE with the FIFO non-empty, the block SHALL pop one word into the shift and hold registers, clear the retry counter, and go to START at the same edge.
REQ-018 START SHALL drive 0 for one cycle; the start bit appears on the line at the edge after the pop.
REQ-019 DATA SHALL drive DATA_W bits LSB first, one per cycle.
REQ-020 PARITY SHALL drive XOR of the hold word (even mode) or its inverse (odd mode) for one cycle; the state SHALL be skipped when PARITY_MODE is 0.
REQ-021 STOP SHALL drive 1 for STOP_BITS cycles.
REQ-022 CHECK SHALL last one cycle with the line at 1, then act on Flag_in:
  - Flag_in 0: pulse DoneTx, go to IDLE.
  - Flag_in 1 and retry count < MAX_RETRY: increment the count, reload the shift register from hold, go to START.
  - Flag_in 1 and retry count = MAX_RETRY: pulse ErrTx, drop the frame, go to IDLE.
REQ-023 Frame length SHALL be 1 + DATA_W + (PARITY_MODE != 0) + STOP_BITS + 1 (CHECK) cycles.
REQ-024 Push SHALL be ignored when Ready is 0; no overwrite and no error flag.
REQ-025 A simultaneous push and pop SHALL be legal when the FIFO is neither empty nor full; the occupancy stays unchanged.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; the occupancy counter SHALL be $clog2(FIFO_DEPTH)+1 bits wide.
REQ-027 Words SHALL be transmitted in push order, including across retries; a retry never pops a new word.
REQ-028 Outside START, DATA and PARITY, the line SHALL be 1.

Reset
REQ-029 While RstTx_n is 0, the block SHALL immediately force the following, including mid-frame:
  - TransmittedSerialData=1
  - DoneTx=0, ErrTx=0, Busy=0
  - state=IDLE
  - FIFO empty (Ready=1)
  - retry count=0
REQ-030 After reset release, the first frame SHALL start no earlier than the second rising edge.

Structure
REQ-031 The state enum and the PARITY_NONE/EVEN/ODD constants SHALL live in the shared package uart_pkg.
REQ-032 The FIFO SHALL be a sub-module, uart_tx_fifo (DATA_W and FIFO_DEPTH parameters, push/pop/full/empty/count ports, same clock and reset).

Verification
REQ-033 Defaults, push 0xA5, Flag_in 0 -> line 0, 1,0,1,0,0,1,0,1, parity 0, stop 1; DoneTx pulses once in CHECK.
REQ-034 PARITY_MODE=2, STOP_BITS=2, push 0xA5 -> parity bit 1, two stop bits, frame 13 cycles.
REQ-035 Flag_in 1 at the first two CHECKs, then 0 -> identical frame sent 3 times; one DoneTx, no ErrTx.
REQ-036 MAX_RETRY=3, Flag_in stuck 1 -> 4 transmissions, ErrTx pulse, next FIFO word then starts.
REQ-037 FIFO_DEPTH=4, NewData high 6 consecutive cycles from IDLE with words 1..6 -> words 1..5 accepted, Ready low on the 6th, word 6 never sent, output order 1..5.
REQ-038 Assert RstTx_n=0 during DATA of the second of three queued frames -> line 1 in the same cycle, FIFO empty, no DoneTx; the next push transmits normally.
